// File: rtl/rr_bus_arbiter.sv
// Fair 12-master bus arbiter: strict priority across three groups of four, round-robin within a
// group, with pickup timeout and bus-hold limit. Define RR_ARB_PREEMPT_EN to add the preempt hint.
module rr_bus_arbiter #(
  parameter int unsigned TAKE_TIMEOUT = 15,
  parameter int unsigned HOLD_LIMIT   = 1023,
  parameter int unsigned CNT_W        = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] m_reqs,
  input  logic [11:0] m_block,
  input  logic        bus_util,
  output logic [11:0] m_grants,
  output logic [3:0]  mid_current,
  output logic        fault,
  input  logic        fault_clr,
`ifdef RR_ARB_PREEMPT_EN
  output logic        preempt,
`endif
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSelect   = 3'd1,
    StWaitFree = 3'd2,
    StGrant    = 3'd3,
    StWaitTake = 3'd4,
    StOwned    = 3'd5,
    StRelease  = 3'd6
  } state_e;

  localparam logic [3:0] MidNone = 4'hF;

  state_e           state_q, state_d;
  logic [3:0]       mid_sel_q, mid_sel_d;
  logic [2:0][1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [11:0]      grants_q, grants_d;
  logic [3:0]       mid_cur_q, mid_cur_d;
  logic             fault_q, fault_d, fault_set;

  logic [11:0] elig;
  logic [2:0]  grp_any;
  logic        any_elig;
  logic [1:0]  sel_grp, sel_off, scan_ptr, scan_idx;
  logic [3:0]  grp_elig;
  logic        grp_found, off_found;
  logic [3:0]  sel_mid;
  logic [11:0] sel_onehot;

  assign elig       = m_reqs & ~m_block;
  assign grp_any    = {|elig[11:8], |elig[7:4], |elig[3:0]};
  assign any_elig   = |grp_any;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign sel_onehot = 12'd1 << mid_sel_q;

  // Lowest-numbered active group wins; inside it, scan from that group's pointer with wrap.
  always_comb begin
    sel_grp   = 2'd0;
    grp_found = 1'b0;
    for (int g = 0; g < 3; g++) begin
      if (!grp_found && grp_any[g]) begin
        sel_grp   = 2'(g);
        grp_found = 1'b1;
      end
    end
    case (sel_grp)
      2'd1: begin
        grp_elig = elig[7:4];
        scan_ptr = rr_ptr_q[1];
      end
      2'd2: begin
        grp_elig = elig[11:8];
        scan_ptr = rr_ptr_q[2];
      end
      default: begin
        grp_elig = elig[3:0];
        scan_ptr = rr_ptr_q[0];
      end
    endcase
    sel_off   = scan_ptr;
    off_found = 1'b0;
    scan_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = scan_ptr + 2'(k);
      if (!off_found && grp_elig[scan_idx]) begin
        sel_off   = scan_idx;
        off_found = 1'b1;
      end
    end
  end

  assign sel_mid = {sel_grp, sel_off};

  // Grant registers are loaded on entry to StGrant so the grant is visible while in that state.
  always_comb begin
    state_d   = state_q;
    mid_sel_d = mid_sel_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    grants_d  = grants_q;
    mid_cur_d = mid_cur_q;
    fault_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_elig) state_d = StSelect;
      end
      StSelect: begin
        if (any_elig) begin
          mid_sel_d = sel_mid;
          state_d   = StWaitFree;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitFree: begin
        if (bus_util) begin
          grants_d  = sel_onehot;
          mid_cur_d = mid_sel_q;
          cnt_d     = '0;
          case (mid_sel_q[3:2])
            2'd1:    rr_ptr_d[1] = mid_sel_q[1:0] + 2'd1;
            2'd2:    rr_ptr_d[2] = mid_sel_q[1:0] + 2'd1;
            default: rr_ptr_d[0] = mid_sel_q[1:0] + 2'd1;
          endcase
          state_d = StGrant;
        end
      end
      StGrant: begin
        cnt_d   = '0;
        state_d = StWaitTake;
      end
      StWaitTake: begin
        if (!bus_util) begin
          cnt_d   = '0;
          state_d = StOwned;
        end else if (cnt_inc == CNT_W'(TAKE_TIMEOUT)) begin
          grants_d  = '0;
          mid_cur_d = MidNone;
          fault_set = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StOwned: begin
        // A release on the limit cycle takes precedence: no fault.
        if (bus_util) begin
          grants_d  = '0;
          mid_cur_d = MidNone;
          state_d   = StIdle;
        end else if (cnt_inc == CNT_W'(HOLD_LIMIT)) begin
          grants_d  = '0;
          fault_set = 1'b1;
          state_d   = StRelease;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRelease: begin
        if (bus_util) begin
          mid_cur_d = MidNone;
          state_d   = StIdle;
        end
      end
      default: begin
        grants_d  = '0;
        mid_cur_d = MidNone;
        state_d   = StIdle;
      end
    endcase

    fault_d = fault_set | (fault_q & ~fault_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      mid_sel_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      grants_q  <= '0;
      mid_cur_q <= MidNone;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mid_sel_q <= mid_sel_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      grants_q  <= grants_d;
      mid_cur_q <= mid_cur_d;
      fault_q   <= fault_d;
    end
  end

  assign m_grants    = grants_q;
  assign mid_current = mid_cur_q;
  assign fault       = fault_q;
  assign state       = state_q;

`ifdef RR_ARB_PREEMPT_EN
  logic higher_elig;

  always_comb begin
    case (mid_cur_q[3:2])
      2'd1:    higher_elig = grp_any[0];
      2'd2:    higher_elig = |grp_any[1:0];
      default: higher_elig = 1'b0;
    endcase
  end

  assign preempt = (state_q == StOwned) && higher_elig;
`endif

endmodule
